pcm_frame_buffer: RTL

- Downstream of the PDM microphone front-end.
- Consumes its one-cycle `pcm_valid` pulses carrying 16-bit PCM samples and assembles them into fixed-length frames in a ping-pong pair of memory banks.
- The CPU reads a completed frame through a CSR-style random-access read port while the next frame fills.
- Frame completion and dropped frames are reported to LiteX for interrupt and status use.

---
 rtl/pcm_frame_buffer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/pcm_frame_buffer.sv
// pcm_frame_buffer
// Collects PCM samples from the microphone front-end into fixed-length frames.
// Two memory banks alternate: one fills while the CPU reads the other.
// Completed frames are announced on frame_ready. A frame that completes while
// the CPU still holds the read bank is dropped, and overflow/drop_count record it.

module pcm_frame_buffer #(
   parameter int FRAME_LEN = 256,
   parameter int ADDR_W    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic [15:0]       pcm_sample,
   input  logic              pcm_valid,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [15:0]       rd_data,
   output logic              frame_ready,
   input  logic              frame_ack,
   output logic              overflow,
   input  logic              overflow_clear,
   output logic [15:0]       frame_count,
   output logic [15:0]       drop_count,
   output logic [ADDR_W:0]   fill_level
);

   localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(FRAME_LEN - 1);
   localparam logic [ADDR_W-1:0] IDX_ZERO = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

   // Both banks share one array; the bank select is the top address bit.
   logic [15:0]       mem_r [0:2*FRAME_LEN-1];

   logic              wr_bank_r;     // bank being filled; the read bank is its complement
   logic [ADDR_W-1:0] wr_idx_r;
   logic              frame_ready_r;
   logic              overflow_r;
   logic [15:0]       frame_count_r;
   logic [15:0]       drop_count_r;
   logic [15:0]       rd_data_r;

   logic              wr_en_s;
   logic              last_s;
   logic              complete_s;
   logic              drop_s;
   logic [ADDR_W:0]   wr_addr_s;
   logic [ADDR_W:0]   rd_mem_addr_s;

   // Decode the write strobe and the end-of-frame outcome (deliver or drop).
   always_comb begin
      wr_en_s       = enable & pcm_valid;
      last_s        = wr_en_s & (wr_idx_r == IDX_LAST);
      // An ack arriving with the last sample frees the read bank just in time.
      complete_s    = last_s & (~frame_ready_r | frame_ack);
      drop_s        = last_s & frame_ready_r & ~frame_ack;
      wr_addr_s     = {wr_bank_r, wr_idx_r};
      rd_mem_addr_s = {~wr_bank_r, rd_addr};
   end

   // Sample memory write port; contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_r[wr_addr_s] <= pcm_sample;
      end
   end

   // Registered read port from the read bank, one cycle of latency.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_r <= 16'h0000;
      end else begin
         rd_data_r <= mem_r[rd_mem_addr_s];
      end
   end

   // Write index: advances per accepted sample, restarts when capture is disabled.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_idx_r <= IDX_ZERO;
      end else if (!enable) begin
         wr_idx_r <= IDX_ZERO;
      end else if (wr_en_s) begin
         wr_idx_r <= wr_idx_r + IDX_ONE;   // wraps to zero after the last index
      end else begin
         wr_idx_r <= wr_idx_r;
      end
   end

   // Bank ownership, frame_ready handshake and delivered-frame counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_bank_r     <= 1'b0;
         frame_ready_r <= 1'b0;
         frame_count_r <= 16'h0000;
      end else if (complete_s) begin
         wr_bank_r     <= ~wr_bank_r;
         frame_ready_r <= 1'b1;
         frame_count_r <= frame_count_r + 16'h0001;
      end else if (frame_ack) begin
         wr_bank_r     <= wr_bank_r;
         frame_ready_r <= 1'b0;
         frame_count_r <= frame_count_r;
      end else begin
         wr_bank_r     <= wr_bank_r;
         frame_ready_r <= frame_ready_r;
         frame_count_r <= frame_count_r;
      end
   end

   // Drop reporting: sticky overflow flag (a drop beats a clear) and saturating counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_r   <= 1'b0;
         drop_count_r <= 16'h0000;
      end else if (drop_s) begin
         overflow_r   <= 1'b1;
         drop_count_r <= (drop_count_r == 16'hFFFF) ? 16'hFFFF : (drop_count_r + 16'h0001);
      end else if (overflow_clear) begin
         overflow_r   <= 1'b0;
         drop_count_r <= drop_count_r;
      end else begin
         overflow_r   <= overflow_r;
         drop_count_r <= drop_count_r;
      end
   end

   assign rd_data     = rd_data_r;
   assign frame_ready = frame_ready_r;
   assign overflow    = overflow_r;
   assign frame_count = frame_count_r;
   assign drop_count  = drop_count_r;
   assign fill_level  = {1'b0, wr_idx_r};

endmodule
